zbt_disp_reader: RTL and testbench

Display-side reader for the processed-pixel frame in ZBT bank 1. Generates forecast read addresses from the VGA `hcount`/`vcount`, captures the returned 36-bit two-pixel words, and emits one 18-bit pixel per cycle. Pixel and syncs leave the block aligned one cycle behind the raster inputs. It is the read end of the bank-1 address scheme `{vcount, hcount[9:1]}` used by the edge-processing writer; it sits between the ZBT bank-1 read port and the VGA output stage.

---
 rtl/zbt_disp_reader_if.sv | 27 ++
 rtl/zbt_disp_reader.sv | 85 ++++++++
 tb/tb_zbt_disp_reader.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/zbt_disp_reader_if.sv
// rtl/zbt_disp_reader_if.sv - raster, ZBT bank-1 read port and VGA output bundle for the display reader
interface zbt_disp_reader_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic        blank_in;
  logic        pattern_en;
  logic [35:0] read_data;
  logic [18:0] read_addr;
  logic [17:0] pixel;
  logic        hsync_out;
  logic        vsync_out;
  logic        blank_out;

  // Raster source / ZBT model / VGA sink side
  modport master (
    output hcount, vcount, hsync_in, vsync_in, blank_in, pattern_en, read_data,
    input  read_addr, pixel, hsync_out, vsync_out, blank_out
  );

  // Reader side
  modport slave (
    input  hcount, vcount, hsync_in, vsync_in, blank_in, pattern_en, read_data,
    output read_addr, pixel, hsync_out, vsync_out, blank_out
  );
endinterface

// File: rtl/zbt_disp_reader.sv
// rtl/zbt_disp_reader.sv - forecast-address ZBT bank-1 reader emitting one pixel per clock
module zbt_disp_reader #(
  parameter int LAT     = 2,
  parameter int H_TOTAL = 1056,
  parameter int V_TOTAL = 806
) (
  input  logic               clk,
  input  logic               reset,
  zbt_disp_reader_if.slave   bus
);

  // Address is issued F cycles ahead: LAT for the ZBT, one for the address
  // register and one for the word capture register.
  localparam int          F      = LAT + 2;
  localparam logic [10:0] H_WRAP = 11'(H_TOTAL - F);
  localparam logic [10:0] H_STEP = 11'(F);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

  logic [18:0] r_read_addr;
  logic [35:0] r_word;
  logic [17:0] r_pixel;
  logic        r_hsync;
  logic        r_vsync;
  logic        r_blank;

  logic        w_wrap;
  logic [10:0] w_hcount_f;
  logic [9:0]  w_vcount_f;
  logic [17:0] w_half;
  logic [17:0] w_ramp;
  logic [17:0] w_pixel_d;
  logic        w_unused;

  // Forecast raster position F columns ahead, carrying into the next row/frame
  always_comb begin
    w_wrap     = (bus.hcount >= H_WRAP);
    w_hcount_f = bus.hcount + H_STEP;
    w_vcount_f = bus.vcount;
    if (w_wrap) begin
      w_hcount_f = bus.hcount - H_WRAP;
      w_vcount_f = (bus.vcount == V_LAST) ? 10'd0 : bus.vcount + 10'd1;
    end
  end

  // Pixel pair selection and output priority: blank, then test ramp, then ZBT data
  always_comb begin
    w_half    = bus.hcount[0] ? r_word[17:0] : r_word[35:18];
    w_ramp    = {bus.hcount[5:0], bus.vcount[5:0], bus.hcount[9:4]};
    w_pixel_d = w_half;
    if (bus.blank_in) begin
      w_pixel_d = 18'd0;
    end else if (bus.pattern_en) begin
      w_pixel_d = w_ramp;
    end
  end

  // Column bit 0 picks the half, bit 10 never reaches the bank address
  assign w_unused = &{1'b0, w_hcount_f[10], w_hcount_f[0]};

  // Address, captured word, pixel and sync delay registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_read_addr <= 19'd0;
      r_word      <= 36'd0;
      r_pixel     <= 18'd0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_blank     <= 1'b1;
    end else begin
      r_read_addr <= {w_vcount_f, w_hcount_f[9:1]};
      r_word      <= bus.read_data;
      r_pixel     <= w_pixel_d;
      r_hsync     <= bus.hsync_in;
      r_vsync     <= bus.vsync_in;
      r_blank     <= bus.blank_in;
    end
  end

  assign bus.read_addr = r_read_addr;
  assign bus.pixel     = r_pixel;
  assign bus.hsync_out = r_hsync;
  assign bus.vsync_out = r_vsync;
  assign bus.blank_out = r_blank;

endmodule

// File: tb/tb_zbt_disp_reader.sv
// tb/tb_zbt_disp_reader.sv - scoreboard bench for zbt_disp_reader
module tb_zbt_disp_reader;

  localparam int K_ADDR  = 0;
  localparam int K_PIXEL = 1;
  localparam int K_HS    = 2;
  localparam int K_VS    = 3;
  localparam int K_BLANK = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [18:0] val;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_chk;
  int   n_err;
  exp_t q[$];

  logic [18:0] zbt_pipe;

  int prev_h;
  int prev_v;
  int run;

  zbt_disp_reader_if bus();

  zbt_disp_reader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ZBT bank-1 model, read latency 2: word = {addr[17:0], ~addr[17:0]}
  always @(posedge clk) begin
    zbt_pipe      <= bus.read_addr;
    bus.read_data <= {zbt_pipe[17:0], ~zbt_pipe[17:0]};
  end

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [18:0] fc_addr(input int h, input int v);
    int hf;
    int vf;
    logic [10:0] hb;
    logic [9:0]  vb;
    if (h >= 1052) begin
      hf = h - 1052;
      vf = (v == 805) ? 0 : v + 1;
    end else begin
      hf = h + 4;
      vf = v;
    end
    hb = 11'(hf);
    vb = 10'(vf);
    return {vb, hb[9:1]};
  endfunction

  function automatic logic [17:0] model_pixel(input int h, input int v);
    logic [10:0] hb;
    logic [9:0]  vb;
    logic [18:0] a;
    logic [35:0] w;
    hb = 11'(h);
    vb = 10'(v);
    a  = {vb, hb[9:1]};
    w  = {a[17:0], ~a[17:0]};
    return hb[0] ? w[17:0] : w[35:18];
  endfunction

  task automatic push(input int kind, input logic [18:0] val, input string nm);
    exp_t e;
    e.due  = cyc + 1;
    e.kind = kind;
    e.val  = val;
    e.name = nm;
    q.push_back(e);
  endtask

  // One raster cycle: drive inputs away from the edge and queue expected outputs
  task automatic step(input int h, input int v, input bit hs, input bit vs, input bit bl, input bit pe);
    logic [10:0] hb;
    logic [5:0]  vlo;
    bit          cont;
    @(posedge clk);
    #2;
    bus.hcount     = 11'(h);
    bus.vcount     = 10'(v);
    bus.hsync_in   = hs;
    bus.vsync_in   = vs;
    bus.blank_in   = bl;
    bus.pattern_en = pe;
    cont = (h == prev_h + 1 && v == prev_v) ||
           (h == 0 && prev_h == 1055 && v == ((prev_v == 805) ? 0 : prev_v + 1));
    run    = cont ? run + 1 : 0;
    prev_h = h;
    prev_v = v;
    hb  = 11'(h);
    vlo = 6'(v);
    push(K_ADDR,  fc_addr(h, v), "read_addr");
    push(K_HS,    19'(hs), "hsync_out");
    push(K_VS,    19'(vs), "vsync_out");
    push(K_BLANK, 19'(bl), "blank_out");
    if (bl)
      push(K_PIXEL, 19'd0, "pixel_blank");
    else if (pe)
      push(K_PIXEL, {1'b0, hb[5:0], vlo, hb[9:4]}, "pixel_ramp");
    else if (run >= 4)
      push(K_PIXEL, {1'b0, model_pixel(h, v)}, "pixel_data");
  endtask

  // Monitor: compare every expectation that falls due this cycle
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      logic [18:0] act;
      e = q.pop_front();
      case (e.kind)
        K_ADDR:  act = bus.read_addr;
        K_PIXEL: act = {1'b0, bus.pixel};
        K_HS:    act = {18'd0, bus.hsync_out};
        K_VS:    act = {18'd0, bus.vsync_out};
        default: act = {18'd0, bus.blank_out};
      endcase
      if (e.due < cyc) begin
        n_chk++;
        n_err++;
        $display("FAIL %s: stale expectation due %0d at cycle %0d", e.name, e.due, cyc);
      end else begin
        check(e.name, act, e.val);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_addr"},  bus.read_addr, 19'd0);
    check({tag, "_pixel"}, {1'b0, bus.pixel}, 19'd0);
    check({tag, "_hs"},    {18'd0, bus.hsync_out}, 19'd1);
    check({tag, "_vs"},    {18'd0, bus.vsync_out}, 19'd1);
    check({tag, "_blank"}, {18'd0, bus.blank_out}, 19'd1);
  endtask

  initial begin
    int budget;
    n_chk = 0;
    n_err = 0;
    cyc   = 0;
    run   = 0;
    prev_h = -10;
    prev_v = -10;
    reset  = 1'b0;
    bus.hcount     = 11'd0;
    bus.vcount     = 10'd0;
    bus.hsync_in   = 1'b1;
    bus.vsync_in   = 1'b1;
    bus.blank_in   = 1'b1;
    bus.pattern_en = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("reset");
    reset = 1'b1;

    // Address forecast, hand-computed values
    step(100, 10, 1, 1, 0, 0); push(K_ADDR, {10'd10, 9'd52}, "fc_100");
    step(101, 10, 1, 1, 0, 0); push(K_ADDR, {10'd10, 9'd52}, "fc_101");
    step(102, 10, 1, 1, 0, 0); push(K_ADDR, {10'd10, 9'd53}, "fc_102");

    // Line and frame wrap
    step(1052, 20,  1, 1, 1, 0); push(K_ADDR, {10'd21,  9'd0},  "wrap_line");
    step(1053, 805, 1, 1, 1, 0); push(K_ADDR, {10'd0,   9'd0},  "wrap_frame");
    step(1051, 805, 1, 1, 1, 0); push(K_ADDR, {10'd805, 9'd15}, "pre_wrap");

    // Pattern mode
    step(12'h135, 8'h2A, 1, 1, 0, 1); push(K_PIXEL, {1'b0, 6'h35, 6'h2A, 6'h13}, "ramp_const");

    // Full line of data, hsync toggles at 1048, vsync toggles at row start
    for (int h = 1040; h < 1056; h++)
      step(h, 5, (h < 1048), 1, 1, 0);
    for (int h = 0; h < 1056; h++)
      step(h, 6, (h < 1048), (h >= 2), (h >= 1024), 0);
    for (int h = 0; h < 12; h++)
      step(h, 7, 1, 1, 0, 0);

    // Data across the frame wrap
    for (int h = 1046; h < 1056; h++)
      step(h, 805, 1, 0, 0, 0);
    for (int h = 0; h < 10; h++)
      step(h, 0, 1, 1, 0, 0);

    // Async reset mid-line with outputs held away from their reset values
    for (int h = 494; h <= 500; h++)
      step(h, 9, 0, 0, 0, 0);
    @(posedge clk);
    #7;
    reset = 1'b0;
    #1;
    check_reset_vals("async_reset");
    @(posedge clk);
    #2;
    check_reset_vals("held_reset");
    reset = 1'b1;
    prev_h = -10;
    for (int h = 501; h < 520; h++)
      step(h, 9, (h & 1) == 1, 1, 0, 0);

    budget = 0;
    while (q.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    @(posedge clk);
    n_chk++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
